sq_accum: RTL and testbench

SQ_ACCUM -- requirements
Module: sq_accum

---
 rtl/sq_accum_pkg.sv | 19 +
 rtl/sq_accum.sv | 125 ++++++++++++
 tb/tb_sq_accum.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sq_accum_pkg.sv
// Shared types and constants for the sum-of-squares frame accumulator.
package sq_accum_pkg;

    // Frame FSM: collecting samples, or presenting a finished result.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Bit positions inside out_flags.
    localparam int FLAG_OVF   = 0;  // sum carried out of ACC_W this frame
    localparam int FLAG_TRUNC = 1;  // frame closed by MAX_LEN, not in_last
    localparam int FLAG_OVRUN = 2;  // sample offered while busy (sticky)
    localparam int NUM_FLAGS  = 3;

    localparam int DEFAULT_ACC_W = 48;

endpackage : sq_accum_pkg

// File: rtl/sq_accum.sv
// sq_accum: accumulates unsigned squares from an upstream squarer into
// per-frame sums. A frame ends on in_last or after MAX_LEN samples; the
// result is held until the downstream handshake.
// Build option: define SQ_ACCUM_SAT_EN to clamp the sum at 2^ACC_W-1 on
// overflow (default build wraps modulo 2^ACC_W). Overflow is flagged
// in both builds.
module sq_accum
    import sq_accum_pkg::*;
#(
    parameter  int W       = 17,
    parameter  int ACC_W   = DEFAULT_ACC_W,
    parameter  int MAX_LEN = 1024,
    localparam int DW      = 2*W + 2,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic [CW-1:0]        out_count,
    output logic [NUM_FLAGS-1:0] out_flags
);

    localparam int SW = ACC_W + 1;

    // The accumulator must hold at least one full sample.
    if (ACC_W < DW) begin : g_bad_acc_w
        $error("sq_accum: ACC_W must be >= 2*W+2");
    end

    state_t               state;
    logic                 hold_q;
    logic [ACC_W-1:0]     acc;
    logic [CW-1:0]        cnt;
    logic [NUM_FLAGS-1:0] flags;

    logic [SW-1:0]        sum_ext;
    logic                 carry;
    logic [ACC_W-1:0]     acc_nxt;
    logic [CW-1:0]        cnt_nxt;
    logic                 len_hit;

    // One-bit-wider add so the carry out of ACC_W is visible; saturate or
    // wrap depending on the build. Once a frame has overflowed in the
    // saturating build it stays pinned at full scale.
    always_comb begin
        sum_ext = {1'b0, acc} + SW'(in_data);
        carry   = sum_ext[ACC_W];
`ifdef SQ_ACCUM_SAT_EN
        acc_nxt = (carry || flags[FLAG_OVF]) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        acc_nxt = sum_ext[ACC_W-1:0];
`endif
        cnt_nxt = cnt + CW'(1);
        len_hit = (cnt_nxt == CW'(MAX_LEN));
    end

    // Frame FSM, accumulator, counter and flags. Results live in acc/cnt
    // directly, so they are naturally stable while waiting in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            hold_q <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            flags  <= '0;
        end else begin
            // Anything offered while the result is pending is lost.
            if (in_valid && hold_q)
                flags[FLAG_OVRUN] <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc              <= ACC_W'(in_data);
                        cnt              <= CW'(1);
                        flags[FLAG_OVF]  <= 1'b0;
                        flags[FLAG_TRUNC] <= !in_last && (MAX_LEN == 1);
                        if (in_last || (MAX_LEN == 1)) begin
                            state  <= ST_HOLD;
                            hold_q <= 1'b1;
                        end else begin
                            state  <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_nxt;
                        cnt <= cnt_nxt;
                        if (carry)
                            flags[FLAG_OVF] <= 1'b1;
                        if (in_last || len_hit) begin
                            flags[FLAG_TRUNC] <= !in_last;
                            state  <= ST_HOLD;
                            hold_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state  <= ST_IDLE;
                        hold_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    hold_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = !hold_q;
    assign out_valid = hold_q;
    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_flags = flags;

endmodule : sq_accum

// File: tb/tb_sq_accum.sv
// Directed bench for sq_accum. Instance A (W=17, ACC_W=48, MAX_LEN=4)
// covers framing, hold, truncation, overrun and reset; instance B
// (W=3, ACC_W=8) covers overflow in whichever build is selected.
module tb_sq_accum;

    localparam int A_W = 17, A_ACC = 48, A_ML = 4;
    localparam int A_DW = 2*A_W + 2, A_CW = $clog2(A_ML + 1);
    localparam int B_W = 3, B_ACC = 8, B_ML = 1024;
    localparam int B_DW = 2*B_W + 2, B_CW = $clog2(B_ML + 1);

    logic clk = 1'b0;
    logic rst;

    logic              a_in_valid, a_in_last, a_in_ready, a_out_valid, a_out_ready;
    logic [A_DW-1:0]   a_in_data;
    logic [A_ACC-1:0]  a_out_sum;
    logic [A_CW-1:0]   a_out_count;
    logic [2:0]        a_out_flags;

    logic              b_in_valid, b_in_last, b_in_ready, b_out_valid, b_out_ready;
    logic [B_DW-1:0]   b_in_data;
    logic [B_ACC-1:0]  b_out_sum;
    logic [B_CW-1:0]   b_out_count;
    logic [2:0]        b_out_flags;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sq_accum #(.W(A_W), .ACC_W(A_ACC), .MAX_LEN(A_ML)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_last(a_in_last), .in_data(a_in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_count(a_out_count), .out_flags(a_out_flags)
    );

    sq_accum #(.W(B_W), .ACC_W(B_ACC), .MAX_LEN(B_ML)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_last(b_in_last), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_count(b_out_count), .out_flags(b_out_flags)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample to A for exactly one edge.
    task automatic a_push(input logic [A_DW-1:0] d, input logic last);
        a_in_valid = 1'b1; a_in_data = d; a_in_last = last;
        tick();
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic b_push(input logic [B_DW-1:0] d, input logic last);
        b_in_valid = 1'b1; b_in_data = d; b_in_last = last;
        tick();
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    task automatic a_result(input string tag, input int sum, input int cnt, input int flg);
        check({tag, "_valid"}, a_out_valid, 1);
        check({tag, "_ready"}, a_in_ready, 0);
        check({tag, "_sum"},   a_out_sum,   sum);
        check({tag, "_count"}, a_out_count, cnt);
        check({tag, "_flags"}, a_out_flags, flg);
    endtask

`ifdef SQ_ACCUM_SAT_EN
    localparam int B_OVF2 = 255;  // 200+100 clamps
    localparam int B_OVF3 = 255;  // stays clamped after +5
`else
    localparam int B_OVF2 = 44;   // 300 mod 256
    localparam int B_OVF3 = 49;   // 44 + 5
`endif

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_in_last = 0; a_in_data = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_last = 0; b_in_data = '0; b_out_ready = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", a_out_valid, 0);
        check("rst_ready", a_in_ready, 1);
        check("rst_sum",   a_out_sum, 0);
        check("rst_count", a_out_count, 0);
        check("rst_flags", a_out_flags, 0);
        check("rst_b_sum", b_out_sum, 0);

        // 4 + 9 + 16, result visible right after the last is accepted
        a_out_ready = 1'b1;
        a_push(4, 0);
        a_push(9, 0);
        check("f1_early_valid", a_out_valid, 0);
        a_push(16, 1);
        a_result("f1", 29, 3, 0);
        tick();
        check("f1_done", a_out_valid, 0);

        // Single sample held under back-pressure for 5 cycles
        a_out_ready = 1'b0;
        a_push(100, 1);
        for (int i = 0; i < 5; i++) begin
            a_result("hold", 100, 1, 0);
            tick();
        end
        a_out_ready = 1'b1;
        tick();
        check("hold_rel_valid", a_out_valid, 0);
        check("hold_rel_ready", a_in_ready, 1);

        // out_ready while idle does nothing
        tick();
        check("idle_rdy_valid", a_out_valid, 0);
        check("idle_rdy_count", a_out_count, 1);

        // Six 1s, no in_last: MAX_LEN=4 truncates, remaining two form the next frame
        for (int i = 0; i < 4; i++) a_push(1, 0);
        a_result("trunc", 4, 4, 3'b010);
        tick();
        a_push(1, 0);
        a_push(1, 1);
        a_result("trunc_next", 2, 2, 0);
        tick();

        // in_last on the MAX_LEN-th sample closes normally
        a_push(1, 0); a_push(2, 0); a_push(3, 0); a_push(4, 1);
        a_result("full_last", 10, 4, 0);
        tick();

        // Sample offered during HOLD is dropped and sets sticky overrun
        a_out_ready = 1'b0;
        a_push(7, 1);
        a_in_valid = 1'b1; a_in_data = 50;
        tick();
        a_in_valid = 1'b0;
        a_result("ovrun", 7, 1, 3'b100);
        a_out_ready = 1'b1;
        tick();
        check("ovrun_idle_flags", a_out_flags, 3'b100);
        a_push(3, 1);
        a_result("ovrun_next", 3, 1, 3'b100);
        tick();

        // Reset mid-frame discards partial sum and clears sticky bit
        a_push(5, 0);
        a_push(6, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", a_out_valid, 0);
        check("mrst_sum",   a_out_sum, 0);
        check("mrst_count", a_out_count, 0);
        check("mrst_flags", a_out_flags, 0);
        a_push(5, 1);
        a_result("mrst_next", 5, 1, 0);
        tick();

        // Overflow on the narrow instance
        b_out_ready = 1'b1;
        b_push(200, 0);
        b_push(100, 1);
        check("ovf_valid", b_out_valid, 1);
        check("ovf_sum",   b_out_sum, B_OVF2);
        check("ovf_count", b_out_count, 2);
        check("ovf_flags", b_out_flags, 3'b001);
        tick();
        b_push(200, 0); b_push(100, 0); b_push(5, 1);
        check("ovf3_sum",   b_out_sum, B_OVF3);
        check("ovf3_flags", b_out_flags, 3'b001);
        tick();
        b_push(1, 1);
        check("ovf_clr_sum",   b_out_sum, 1);
        check("ovf_clr_flags", b_out_flags, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sq_accum
